mima_kongzhi: RTL and testbench

- Password-lock sequencer for the four-digit keypad and display path.
- Takes key events from the keypad scanner, collects up to four digits, and compares them with the stored password.
- Drives the four display nibbles plus the unlock, alarm and lockout outputs.
- Supports a failure counter, lockout, entry timeout and password change while open.

---
 rtl/mima_kongzhi.sv | 172 +++++++++++++++++
 tb/tb_mima_kongzhi.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mima_kongzhi.sv
// rtl/mima_kongzhi.sv - four-digit password lock sequencer with lockout, timeout and password change
module mima_kongzhi #(
    parameter logic [15:0] DEFAULT_PW     = 16'h1234,
    parameter int          MAX_FAIL       = 3,
    parameter int          TIMEOUT_CYCLES = 250000000,
    parameter int          OPEN_CYCLES    = 150000000,
    parameter int          LOCK_CYCLES    = 500000000,
    parameter int          CW             = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] keycode,
    input  logic       key_ready,
    output logic [3:0] segData_1,
    output logic [3:0] segData_2,
    output logic [3:0] segData_3,
    output logic [3:0] segData_4,
    output logic       unlock,
    output logic       alarm,
    output logic [2:0] fail_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_ENTRY, S_CHECK, S_OPEN, S_FAIL, S_LOCKOUT, S_NEW_PW
    } state_t;

    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] OPEN_LAST = CW'(OPEN_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);
    localparam logic [CW-1:0] FAIL_LAST = CW'(15);
    localparam logic [2:0]    MAX_FAIL_C = 3'(MAX_FAIL);

    state_t        state_q;
    logic          key_q;
    logic [4:0]    code_q;
    logic [15:0]   buf_q;
    logic [15:0]   pw_q;
    logic [2:0]    num_q;
    logic [CW-1:0] cnt_q;
    logic [15:0]   disp_d;
    logic          ev;
    logic          is_digit;
    logic [2:0]    fail_inc;

    // Event fires on key release and uses the code held while the key was down.
    assign ev       = key_q & ~key_ready;
    assign is_digit = ev && (code_q <= 5'd9);
    assign fail_inc = fail_cnt + 3'd1;

    always_comb begin
        disp_d = {4{4'd13}};
        case (state_q)
            S_ENTRY, S_CHECK: begin
                for (int i = 0; i < 4; i++)
                    if (num_q > 3'(i)) disp_d[4*i +: 4] = 4'd10;
            end
            S_NEW_PW: begin
                for (int i = 0; i < 4; i++)
                    if (num_q > 3'(i)) disp_d[4*i +: 4] = buf_q[4*i +: 4];
            end
            S_OPEN:             disp_d = {4{4'd15}};
            S_FAIL, S_LOCKOUT:  disp_d = {4{4'd14}};
            default:            disp_d = {4{4'd13}};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            key_q     <= 1'b0;
            code_q    <= '0;
            buf_q     <= '0;
            pw_q      <= DEFAULT_PW;
            num_q     <= '0;
            cnt_q     <= '0;
            fail_cnt  <= '0;
            unlock    <= 1'b0;
            alarm     <= 1'b0;
            segData_1 <= 4'd13;
            segData_2 <= 4'd13;
            segData_3 <= 4'd13;
            segData_4 <= 4'd13;
        end else begin
            key_q <= key_ready;
            if (key_ready) code_q <= keycode;
            unlock <= (state_q == S_OPEN);
            alarm  <= (state_q == S_LOCKOUT);
            {segData_4, segData_3, segData_2, segData_1} <= disp_d;
            if (cnt_q != '1) cnt_q <= cnt_q + CW'(1);

            case (state_q)
                S_IDLE: begin
                    if (is_digit) begin
                        buf_q   <= {12'h000, code_q[3:0]};
                        num_q   <= 3'd1;
                        state_q <= S_ENTRY;
                        cnt_q   <= '0;
                    end
                end
                S_ENTRY, S_NEW_PW: begin
                    if (ev) begin
                        cnt_q <= '0;
                        if (is_digit) begin
                            if (num_q != 3'd4) begin
                                buf_q <= {buf_q[11:0], code_q[3:0]};
                                num_q <= num_q + 3'd1;
                            end
                        end else if (code_q == 5'd11) begin
                            buf_q <= '0;
                            num_q <= '0;
                        end else if (code_q == 5'd10) begin
                            if (state_q == S_ENTRY) begin
                                state_q <= S_CHECK;
                            end else if (num_q == 3'd4) begin
                                pw_q    <= buf_q;
                                buf_q   <= '0;
                                num_q   <= '0;
                                state_q <= S_IDLE;
                            end
                        end
                    end else if (cnt_q == TO_LAST) begin
                        buf_q   <= '0;
                        num_q   <= '0;
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end
                end
                S_CHECK: begin
                    buf_q <= '0;
                    num_q <= '0;
                    cnt_q <= '0;
                    if (num_q == 3'd4 && buf_q == pw_q) begin
                        fail_cnt <= '0;
                        state_q  <= S_OPEN;
                    end else begin
                        fail_cnt <= fail_inc;
                        state_q  <= (fail_inc == MAX_FAIL_C) ? S_LOCKOUT : S_FAIL;
                    end
                end
                S_OPEN: begin
                    if (ev && code_q == 5'd12) begin
                        buf_q   <= '0;
                        num_q   <= '0;
                        state_q <= S_NEW_PW;
                        cnt_q   <= '0;
                    end else if (cnt_q == OPEN_LAST) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end
                end
                S_FAIL: begin
                    if (cnt_q == FAIL_LAST) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end
                end
                S_LOCKOUT: begin
                    if (cnt_q == LOCK_LAST) begin
                        fail_cnt <= '0;
                        state_q  <= S_IDLE;
                        cnt_q    <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mima_kongzhi.sv
// tb/tb_mima_kongzhi.sv - self-checking bench for mima_kongzhi against a behavioural lock model
module tb_mima_kongzhi;

    localparam int TO = 40;
    localparam int OC = 20;
    localparam int LC = 30;
    localparam int MF = 3;

    localparam int P_IDLE  = 0;
    localparam int P_ENTRY = 1;
    localparam int P_CHECK = 2;
    localparam int P_OPEN  = 3;
    localparam int P_BAD   = 4;
    localparam int P_LOCK  = 5;
    localparam int P_NEWPW = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] keycode = 5'd31;
    logic       key_ready = 1'b0;
    logic [3:0] segData_1, segData_2, segData_3, segData_4;
    logic       unlock, alarm;
    logic [2:0] fail_cnt;

    mima_kongzhi #(
        .DEFAULT_PW(16'h1234), .MAX_FAIL(MF), .TIMEOUT_CYCLES(TO),
        .OPEN_CYCLES(OC), .LOCK_CYCLES(LC), .CW(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .keycode(keycode), .key_ready(key_ready),
        .segData_1(segData_1), .segData_2(segData_2), .segData_3(segData_3),
        .segData_4(segData_4), .unlock(unlock), .alarm(alarm), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int unl_cyc = 0;
    int alm_cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs as seen by the DUT at each rising edge.
    logic       s_ready;
    logic [4:0] s_code;
    always @(posedge clk) begin
        s_ready <= key_ready;
        s_code  <= keycode;
    end

    int  m_ph;
    int  digs[$];
    int  m_pw[4];
    int  m_age;
    int  m_fail;
    bit  m_prev;
    int  m_code;
    int  e_disp;
    bit  e_unl;
    bit  e_alm;

    function automatic int disp_act();
        return int'({segData_4, segData_3, segData_2, segData_1});
    endfunction

    function automatic int exp_disp();
        int r;
        int n;
        r = 0;
        n = digs.size();
        for (int i = 0; i < 4; i++) begin
            int v;
            v = 13;
            if (m_ph == P_OPEN) v = 15;
            else if (m_ph == P_BAD || m_ph == P_LOCK) v = 14;
            else if ((m_ph == P_ENTRY || m_ph == P_CHECK) && i < n) v = 10;
            else if (m_ph == P_NEWPW && i < n) v = digs[n-1-i];
            r = r | (v << (4*i));
        end
        return r;
    endfunction

    task automatic model_reset();
        m_ph = P_IDLE;
        digs.delete();
        m_pw[0] = 1; m_pw[1] = 2; m_pw[2] = 3; m_pw[3] = 4;
        m_age = 0;
        m_fail = 0;
        m_prev = 1'b0;
        m_code = 0;
    endtask

    task automatic model_step();
        bit ev;
        int code;
        int cur;
        int nph;
        bit ok;
        ev = m_prev && !s_ready;
        code = m_code;
        m_prev = s_ready;
        if (s_ready) m_code = int'(s_code);
        cur = m_age;
        m_age = cur + 1;
        nph = m_ph;
        case (m_ph)
            P_IDLE: if (ev && code <= 9) begin
                digs.delete();
                digs.push_back(code);
                nph = P_ENTRY;
            end
            P_ENTRY, P_NEWPW: begin
                if (ev) begin
                    m_age = 0;
                    if (code <= 9) begin
                        if (digs.size() < 4) digs.push_back(code);
                    end else if (code == 11) begin
                        digs.delete();
                    end else if (code == 10) begin
                        if (m_ph == P_ENTRY) nph = P_CHECK;
                        else if (digs.size() == 4) begin
                            for (int i = 0; i < 4; i++) m_pw[i] = digs[i];
                            digs.delete();
                            nph = P_IDLE;
                        end
                    end
                end else if (cur == TO - 1) begin
                    digs.delete();
                    nph = P_IDLE;
                end
            end
            P_CHECK: begin
                ok = (digs.size() == 4);
                if (ok) for (int i = 0; i < 4; i++) if (digs[i] != m_pw[i]) ok = 1'b0;
                if (ok) begin
                    m_fail = 0;
                    nph = P_OPEN;
                end else begin
                    m_fail = m_fail + 1;
                    nph = (m_fail == MF) ? P_LOCK : P_BAD;
                end
                digs.delete();
            end
            P_OPEN: begin
                if (ev && code == 12) begin
                    digs.delete();
                    nph = P_NEWPW;
                end else if (cur == OC - 1) nph = P_IDLE;
            end
            P_BAD:  if (cur == 15) nph = P_IDLE;
            P_LOCK: if (cur == LC - 1) begin
                m_fail = 0;
                nph = P_IDLE;
            end
            default: nph = P_IDLE;
        endcase
        if (nph != m_ph) m_age = 0;
        m_ph = nph;
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_reset();
                check("rst_disp", disp_act(), 16'hDDDD);
                check("rst_unlock", int'(unlock), 0);
                check("rst_alarm", int'(alarm), 0);
                check("rst_fail", int'(fail_cnt), 0);
            end else begin
                e_disp = exp_disp();
                e_unl  = (m_ph == P_OPEN);
                e_alm  = (m_ph == P_LOCK);
                model_step();
                check("disp", disp_act(), e_disp);
                check("unlock", int'(unlock), int'(e_unl));
                check("alarm", int'(alarm), int'(e_alm));
                check("fail_cnt", int'(fail_cnt), m_fail);
                if (unlock) unl_cyc++;
                if (alarm) alm_cyc++;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic press(input int k);
        keycode = 5'(k);
        key_ready = 1'b1;
        repeat (2) @(negedge clk);
        key_ready = 1'b0;
        keycode = 5'd31;
        repeat (3) @(negedge clk);
    endtask

    // '0'-'9' digits, '#' enter, '*' clear, 'C' change password
    task automatic keys(input string s);
        for (int i = 0; i < s.len(); i++) begin
            byte c;
            c = s[i];
            if (c == "#") press(10);
            else if (c == "*") press(11);
            else if (c == "C") press(12);
            else press(int'(c) - 48);
        end
    endtask

    int u0;
    int a0;

    initial begin
        do_reset();
        check("lit_reset_disp", disp_act(), 16'hDDDD);
        check("lit_reset_unlock", int'(unlock), 0);

        keys("1234");
        check("lit_mask4", disp_act(), 16'hAAAA);
        u0 = unl_cyc;
        keys("#");
        check("lit_open_disp", disp_act(), 16'hFFFF);
        check("lit_open_unlock", int'(unlock), 1);
        repeat (30) @(negedge clk);
        check("lit_open_len", unl_cyc - u0, 20);
        check("lit_open_fail", int'(fail_cnt), 0);

        keys("123#");
        check("lit_fail1", int'(fail_cnt), 1);
        check("lit_fail_disp", disp_act(), 16'hEEEE);
        repeat (20) @(negedge clk);
        keys("9999#");
        check("lit_fail2", int'(fail_cnt), 2);
        repeat (20) @(negedge clk);
        a0 = alm_cyc;
        keys("1235#");
        check("lit_fail3", int'(fail_cnt), 3);
        check("lit_alarm_on", int'(alarm), 1);
        keys("1234#");
        check("lit_lock_ignore", int'(unlock), 0);
        repeat (10) @(negedge clk);
        check("lit_alarm_len", alm_cyc - a0, 30);
        check("lit_lock_clear", int'(fail_cnt), 0);
        check("lit_lock_idle", disp_act(), 16'hDDDD);

        keys("12345#");
        check("lit_fifth_ignored", int'(unlock), 1);
        repeat (25) @(negedge clk);

        keys("77*1234#");
        check("lit_clear_unlock", int'(unlock), 1);
        repeat (25) @(negedge clk);

        keys("1234#C5678");
        check("lit_newpw_disp", disp_act(), 16'h5678);
        check("lit_newpw_unlock", int'(unlock), 0);
        keys("#");
        check("lit_newpw_idle", disp_act(), 16'hDDDD);
        keys("1234#");
        check("lit_oldpw_fails", int'(fail_cnt), 1);
        repeat (20) @(negedge clk);
        keys("5678#");
        check("lit_newpw_unlocks", int'(unlock), 1);
        repeat (25) @(negedge clk);

        keys("12");
        check("lit_two_digits", disp_act(), 16'hDDAA);
        repeat (40) @(negedge clk);
        check("lit_timeout_blank", disp_act(), 16'hDDDD);

        keys("5678#C56");
        check("lit_abort_partial", disp_act(), 16'hDD56);
        do_reset();
        check("lit_abort_disp", disp_act(), 16'hDDDD);
        check("lit_abort_unlock", int'(unlock), 0);
        check("lit_abort_alarm", int'(alarm), 0);
        check("lit_abort_fail", int'(fail_cnt), 0);
        keys("1234#");
        check("lit_default_pw", int'(unlock), 1);
        repeat (25) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
